sv39_ptw_walker: RTL

//  Hardware page-table walker, the producer end of the TLB update interface: on a TLB miss it walks
//  the SV39 table in memory from satp.PPN and emits one update (vpn, asid, PTE, is_2M, is_1G) for the
//  TLB to install, or a page-fault pulse. It sits between the MMU miss path and the data-cache port.

---
 rtl/sv39_ptw_walker.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sv39_ptw_walker.sv
// sv39_ptw_walker
//   SV39 hardware page-table walker. On a TLB miss it reads up to three PTEs
//   starting at satp.PPN and produces either a single TLB update pulse or a
//   single page-fault pulse. A/D bits are never written back, so a clear A bit,
//   or a clear D bit on a store, is reported as a fault.
//   Optional build macro: PTW_SUPERPAGE_ALIGN_CHECK_EN. When it is defined, a
//   superpage leaf whose PPN is not aligned to the page size faults.
module sv39_ptw_walker #(
    parameter int ASID_WIDTH = 1,
    parameter int PLEN       = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  walk_valid_i,
    output logic                  walk_ready_o,
    input  logic [38:0]           walk_vaddr_i,
    input  logic [ASID_WIDTH-1:0] walk_asid_i,
    input  logic                  walk_is_store_i,
    input  logic [43:0]           satp_ppn_i,
    output logic                  mem_req_o,
    output logic [PLEN-1:0]       mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    output logic                  update_valid_o,
    output logic [26:0]           update_vpn_o,
    output logic [ASID_WIDTH-1:0] update_asid_o,
    output logic [63:0]           update_pte_o,
    output logic                  update_is_2M_o,
    output logic                  update_is_1G_o,
    output logic                  fault_o,
    output logic [38:0]           fault_vaddr_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DRAIN     = 2'd3
    } state_e;

    state_e                  state_r, state_n_s;
    logic [1:0]              level_r, level_n_s;
    logic [55:0]             ptr_r, ptr_n_s;
    logic [38:0]             vaddr_r;
    logic [ASID_WIDTH-1:0]   asid_r;
    logic                    store_r;
    logic                    ready_r, req_r;
    logic                    upd_valid_r, upd_2m_r, upd_1g_r;
    logic [26:0]             upd_vpn_r;
    logic [ASID_WIDTH-1:0]   upd_asid_r;
    logic [63:0]             upd_pte_r;
    logic                    fault_r;
    logic [38:0]             fault_vaddr_r;

    logic                    capture_s, upd_fire_s, flt_fire_s;
    logic                    pte_bad_s, pte_leaf_s, leaf_fault_s, misalign_s;
    logic [43:0]             pte_ppn_s;
    logic [8:0]              vpn_next_s;

    // PTE decode of the response currently on the memory port
    assign pte_ppn_s    = mem_rdata_i[53:10];
    assign pte_bad_s    = !mem_rdata_i[0] || (mem_rdata_i[2] && !mem_rdata_i[1]);
    assign pte_leaf_s   = mem_rdata_i[1] || mem_rdata_i[3];
    assign leaf_fault_s = !mem_rdata_i[6] || (store_r && !mem_rdata_i[7]) || misalign_s;

`ifdef PTW_SUPERPAGE_ALIGN_CHECK_EN
    assign misalign_s = ((level_r == 2'd2) && (pte_ppn_s[17:0] != 18'd0)) ||
                        ((level_r == 2'd1) && (pte_ppn_s[8:0]  != 9'd0));
`else
    assign misalign_s = 1'b0;
`endif

    // VPN slice used to index the next-lower table
    always_comb begin
        case (level_r)
            2'd2:    vpn_next_s = vaddr_r[29:21];
            2'd1:    vpn_next_s = vaddr_r[20:12];
            default: vpn_next_s = 9'd0;
        endcase
    end

    // Next-state, walk pointer and result-pulse decisions
    always_comb begin
        state_n_s  = state_r;
        level_n_s  = level_r;
        ptr_n_s    = ptr_r;
        capture_s  = 1'b0;
        upd_fire_s = 1'b0;
        flt_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (walk_valid_i && !flush_i) begin
                    capture_s = 1'b1;
                    level_n_s = 2'd2;
                    ptr_n_s   = {satp_ppn_i, walk_vaddr_i[38:30], 3'b000};
                    state_n_s = REQ;
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                if (flush_i) begin
                    // a granted read still owes us a response, so it must be drained
                    state_n_s = mem_gnt_i ? DRAIN : IDLE;
                end else if (mem_gnt_i) begin
                    state_n_s = WAIT_RESP;
                end else begin
                    state_n_s = REQ;
                end
            end
            WAIT_RESP: begin
                if (!mem_rvalid_i) begin
                    state_n_s = flush_i ? DRAIN : WAIT_RESP;
                end else if (flush_i) begin
                    // response arrives with the flush: nothing left to drain
                    state_n_s = IDLE;
                end else if (pte_bad_s) begin
                    flt_fire_s = 1'b1;
                    state_n_s  = IDLE;
                end else if (pte_leaf_s) begin
                    flt_fire_s = leaf_fault_s;
                    upd_fire_s = !leaf_fault_s;
                    state_n_s  = IDLE;
                end else if (level_r == 2'd0) begin
                    flt_fire_s = 1'b1;
                    state_n_s  = IDLE;
                end else begin
                    level_n_s = level_r - 2'd1;
                    ptr_n_s   = {pte_ppn_s, vpn_next_s, 3'b000};
                    state_n_s = REQ;
                end
            end
            DRAIN: begin
                state_n_s = mem_rvalid_i ? IDLE : DRAIN;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Walk context, registered handshake outputs and TLB update / fault results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_r       <= 2'd2;
            ptr_r         <= 56'd0;
            vaddr_r       <= 39'd0;
            asid_r        <= {ASID_WIDTH{1'b0}};
            store_r       <= 1'b0;
            ready_r       <= 1'b1;
            req_r         <= 1'b0;
            upd_valid_r   <= 1'b0;
            upd_vpn_r     <= 27'd0;
            upd_asid_r    <= {ASID_WIDTH{1'b0}};
            upd_pte_r     <= 64'd0;
            upd_2m_r      <= 1'b0;
            upd_1g_r      <= 1'b0;
            fault_r       <= 1'b0;
            fault_vaddr_r <= 39'd0;
        end else begin
            level_r     <= level_n_s;
            ptr_r       <= ptr_n_s;
            ready_r     <= (state_n_s == IDLE);
            req_r       <= (state_n_s == REQ);
            upd_valid_r <= upd_fire_s;
            fault_r     <= flt_fire_s;
            if (capture_s) begin
                vaddr_r <= walk_vaddr_i;
                asid_r  <= walk_asid_i;
                store_r <= walk_is_store_i;
            end
            if (upd_fire_s) begin
                upd_vpn_r  <= vaddr_r[38:12];
                upd_asid_r <= asid_r;
                upd_pte_r  <= mem_rdata_i;
                upd_2m_r   <= (level_r == 2'd1);
                upd_1g_r   <= (level_r == 2'd2);
            end
            if (flt_fire_s) begin
                fault_vaddr_r <= vaddr_r;
            end
        end
    end

    assign walk_ready_o   = ready_r;
    assign mem_req_o      = req_r;
    assign mem_addr_o     = PLEN'(ptr_r);
    assign update_valid_o = upd_valid_r;
    assign update_vpn_o   = upd_vpn_r;
    assign update_asid_o  = upd_asid_r;
    assign update_pte_o   = upd_pte_r;
    assign update_is_2M_o = upd_2m_r;
    assign update_is_1G_o = upd_1g_r;
    assign fault_o        = fault_r;
    assign fault_vaddr_o  = fault_vaddr_r;

endmodule
